// File: rtl/debug_dump_pkg.sv
// -----------------------------------------------------------------------------
// debug_dump_pkg
// Shared definitions for the debug dump initiator:
//   - dump_state_e : FSM states of debug_dump_tx
//   - ASCII_*      : fixed characters placed in the serial stream
//   - nibble_to_hex: 4-bit value to uppercase hex ASCII ('0'-'9', 'A'-'F')
// -----------------------------------------------------------------------------
package debug_dump_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        CAPTURE,
        TX_HI,
        TX_LO,
        TX_SP,
        TX_CR,
        TX_LF,
        FINISH
    } dump_state_e;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    // 'A' - 10, so that adding a nibble in 10..15 lands on 'A'..'F'
    localparam logic [7:0] ASCII_HEX_LETTER_BASE = 8'h37;

    function automatic logic [7:0] nibble_to_hex(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ASCII_ZERO + {4'h0, nib};
        end
        return ASCII_HEX_LETTER_BASE + {4'h0, nib};
    endfunction

endpackage

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// 8N1 UART transmitter with a valid/ready byte interface.
//   clk      : system clock
//   reset_n  : synchronous active-low reset (line returns high immediately)
//   tx_data  : byte to send, taken when tx_valid & tx_ready
//   tx_valid : byte request
//   tx_ready : high while idle and on the final cycle of a stop bit
//   txd      : serial output, idle high
// Frame: start bit 0, 8 data bits LSB first, stop bit 1, each CLKS_PER_BIT
// cycles long. Because tx_ready is raised on the last stop-bit cycle, a byte
// accepted then starts its start bit on the very next cycle (no idle gap).
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    // frame_q[0] is the bit currently on the line; ones are shifted in behind
    // the frame so the line settles high once the stop bit has been sent.
    logic [9:0]       frame_q;
    logic [3:0]       bit_idx_q;
    logic [CNT_W-1:0] clk_cnt_q;
    logic             active_q;

    logic last_cycle;
    logic accept;

    assign last_cycle = active_q && (bit_idx_q == 4'd9) && (clk_cnt_q == CNT_LAST);
    assign tx_ready   = !active_q || last_cycle;
    assign accept     = tx_valid && tx_ready;
    assign txd        = frame_q[0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            frame_q   <= '1;
            bit_idx_q <= '0;
            clk_cnt_q <= '0;
            active_q  <= 1'b0;
        end else if (accept) begin
            frame_q   <= {1'b1, tx_data, 1'b0};
            bit_idx_q <= '0;
            clk_cnt_q <= '0;
            active_q  <= 1'b1;
        end else if (active_q) begin
            if (clk_cnt_q == CNT_LAST) begin
                clk_cnt_q <= '0;
                frame_q   <= {1'b1, frame_q[9:1]};
                if (bit_idx_q == 4'd9) begin
                    active_q <= 1'b0;
                end else begin
                    bit_idx_q <= bit_idx_q + 4'd1;
                end
            end else begin
                clk_cnt_q <= clk_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/debug_dump_tx.sv
// -----------------------------------------------------------------------------
// debug_dump_tx
// Debug-port initiator: on an accepted start it walks either the register
// file or a data-memory window through the debug read ports and sends every
// byte as two uppercase hex characters plus a space over an 8N1 UART, with
// CR LF after every BYTES_PER_LINE bytes and at the end of the dump.
// Ports:
//   clk, reset_n          : clock, synchronous active-low reset
//   start                 : single-cycle request, ignored while busy
//   dump_sel              : 0 = registers, 1 = data memory (sampled on start)
//   dmem_base, dmem_count : data-memory window (sampled on start)
//   debug_enable          : high for the whole dump
//   reg_debug_addr/rdata  : register debug port, data one cycle after address
//   dmem_debug_addr/rdata : data-memory debug port, data one cycle after address
//   uart_txd              : serial output, idle high
//   busy                  : high from accepted start until done
//   done                  : one-cycle pulse after the final LF stop bit
// -----------------------------------------------------------------------------
module debug_dump_tx #(
    parameter int DATA_W         = 8,
    parameter int D_ADDR_W       = 12,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int NUM_DEBUG_REGS = 16,
    parameter int CLKS_PER_BIT   = 868,
    parameter int BYTES_PER_LINE = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      dump_sel,
    input  logic [D_ADDR_W-1:0]       dmem_base,
    input  logic [D_ADDR_W:0]         dmem_count,
    output logic                      debug_enable,
    output logic [REG_ADDR_WIDTH-1:0] reg_debug_addr,
    input  logic [DATA_W-1:0]         reg_debug_rdata,
    output logic [D_ADDR_W-1:0]       dmem_debug_addr,
    input  logic [DATA_W-1:0]         dmem_debug_rdata,
    output logic                      uart_txd,
    output logic                      busy,
    output logic                      done
);

    import debug_dump_pkg::*;

    // Two hex characters per byte only works for byte-wide debug data.
    generate
        if (DATA_W != 8) begin : g_bad_data_w
            $error("debug_dump_tx: DATA_W must be 8");
        end
        if (REG_ADDR_WIDTH > D_ADDR_W) begin : g_bad_reg_w
            $error("debug_dump_tx: REG_ADDR_WIDTH must not exceed D_ADDR_W");
        end
    endgenerate

    localparam int CNT_W  = D_ADDR_W + 1;
    localparam int LINE_W = $clog2(BYTES_PER_LINE + 1);
    localparam logic [CNT_W-1:0]  REG_COUNT = CNT_W'(NUM_DEBUG_REGS);
    localparam logic [LINE_W-1:0] LINE_FULL = LINE_W'(BYTES_PER_LINE);

    dump_state_e                 state_q;
    logic                        mode_mem_q;
    logic [CNT_W-1:0]            count_q;
    logic [D_ADDR_W-1:0]         addr_q;
    logic [LINE_W-1:0]           line_q;
    logic [7:0]                  byte_q;
    logic                        busy_q;
    logic                        debug_enable_q;
    logic                        done_q;
    logic [REG_ADDR_WIDTH-1:0]   reg_addr_q;
    logic [D_ADDR_W-1:0]         dmem_addr_q;

    logic                        start_accept;
    logic [CNT_W-1:0]            start_count;
    logic [D_ADDR_W-1:0]         start_addr;
    logic [D_ADDR_W-1:0]         fetch_addr;
    logic                        fetch_mem;
    logic [7:0]                  tx_data;
    logic                        tx_valid;
    logic                        tx_ready;
    logic                        tx_fire;

    assign start_accept = start && !busy_q;
    assign start_count  = dump_sel ? dmem_count : REG_COUNT;
    assign start_addr   = dump_sel ? dmem_base : '0;

    // Address and port for the next read: taken straight from the start
    // inputs when leaving IDLE, otherwise from the running pointer.
    assign fetch_addr = (state_q == IDLE) ? start_addr : addr_q;
    assign fetch_mem  = (state_q == IDLE) ? dump_sel   : mode_mem_q;

    // Each TX_* state offers its character; the FSM advances on tx_fire.
    always_comb begin
        tx_valid = 1'b0;
        tx_data  = ASCII_SPACE;
        case (state_q)
            TX_HI: begin
                tx_valid = 1'b1;
                tx_data  = nibble_to_hex(byte_q[7:4]);
            end
            TX_LO: begin
                tx_valid = 1'b1;
                tx_data  = nibble_to_hex(byte_q[3:0]);
            end
            TX_SP: begin
                tx_valid = 1'b1;
                tx_data  = ASCII_SPACE;
            end
            TX_CR: begin
                tx_valid = 1'b1;
                tx_data  = ASCII_CR;
            end
            TX_LF: begin
                tx_valid = 1'b1;
                tx_data  = ASCII_LF;
            end
            default: begin
                tx_valid = 1'b0;
                tx_data  = ASCII_SPACE;
            end
        endcase
    end

    assign tx_fire = tx_valid && tx_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            mode_mem_q     <= 1'b0;
            count_q        <= '0;
            addr_q         <= '0;
            line_q         <= '0;
            byte_q         <= '0;
            busy_q         <= 1'b0;
            debug_enable_q <= 1'b0;
            done_q         <= 1'b0;
            reg_addr_q     <= '0;
            dmem_addr_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_accept) begin
                        mode_mem_q     <= dump_sel;
                        count_q        <= start_count;
                        addr_q         <= start_addr;
                        line_q         <= '0;
                        busy_q         <= 1'b1;
                        debug_enable_q <= 1'b1;
                        if (start_count != '0) begin
                            state_q <= ADDR;
                            if (fetch_mem) dmem_addr_q <= fetch_addr;
                            else           reg_addr_q  <= REG_ADDR_WIDTH'(fetch_addr);
                        end else begin
                            // Empty window: the dump is just a line ending.
                            state_q <= TX_CR;
                        end
                    end
                end
                ADDR: begin
                    state_q <= CAPTURE;
                end
                CAPTURE: begin
                    byte_q  <= mode_mem_q ? 8'(dmem_debug_rdata) : 8'(reg_debug_rdata);
                    count_q <= count_q - 1'b1;
                    addr_q  <= addr_q + 1'b1;   // wraps modulo 2^D_ADDR_W
                    line_q  <= line_q + 1'b1;
                    state_q <= TX_HI;
                end
                TX_HI: begin
                    if (tx_fire) state_q <= TX_LO;
                end
                TX_LO: begin
                    if (tx_fire) state_q <= TX_SP;
                end
                TX_SP: begin
                    if (tx_fire) begin
                        // End-of-data takes precedence so a full line that is
                        // also the last one gets a single CR LF.
                        if (count_q == '0) begin
                            state_q <= TX_CR;
                        end else if (line_q == LINE_FULL) begin
                            line_q  <= '0;
                            state_q <= TX_CR;
                        end else begin
                            state_q <= ADDR;
                            if (fetch_mem) dmem_addr_q <= fetch_addr;
                            else           reg_addr_q  <= REG_ADDR_WIDTH'(fetch_addr);
                        end
                    end
                end
                TX_CR: begin
                    if (tx_fire) state_q <= TX_LF;
                end
                TX_LF: begin
                    if (tx_fire) begin
                        if (count_q == '0) begin
                            state_q <= FINISH;
                        end else begin
                            state_q <= ADDR;
                            if (fetch_mem) dmem_addr_q <= fetch_addr;
                            else           reg_addr_q  <= REG_ADDR_WIDTH'(fetch_addr);
                        end
                    end
                end
                FINISH: begin
                    // tx_ready comes back on the last LF stop-bit cycle, so
                    // done lands right as that stop bit completes.
                    if (tx_ready) begin
                        done_q         <= 1'b1;
                        busy_q         <= 1'b0;
                        debug_enable_q <= 1'b0;
                        reg_addr_q     <= '0;
                        dmem_addr_q    <= '0;
                        state_q        <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk      (clk),
        .reset_n  (reset_n),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .txd      (uart_txd)
    );

    assign debug_enable    = debug_enable_q;
    assign reg_debug_addr  = reg_addr_q;
    assign dmem_debug_addr = dmem_addr_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_debug_dump_tx.sv
`timescale 1ns/1ps
module tb_debug_dump_tx;

    localparam int D_ADDR_W = 12;
    localparam int REG_W    = 4;
    localparam int NREG     = 16;
    localparam int CPB      = 4;
    localparam int BPL      = 16;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                start = 1'b0;
    logic                dump_sel = 1'b0;
    logic [D_ADDR_W-1:0] dmem_base = '0;
    logic [D_ADDR_W:0]   dmem_count = '0;
    logic                debug_enable;
    logic [REG_W-1:0]    reg_debug_addr;
    logic [7:0]          reg_debug_rdata = '0;
    logic [D_ADDR_W-1:0] dmem_debug_addr;
    logic [7:0]          dmem_debug_rdata = '0;
    logic                uart_txd;
    logic                busy;
    logic                done;

    always #5 clk = ~clk;

    debug_dump_tx #(
        .DATA_W(8), .D_ADDR_W(D_ADDR_W), .REG_ADDR_WIDTH(REG_W),
        .NUM_DEBUG_REGS(NREG), .CLKS_PER_BIT(CPB), .BYTES_PER_LINE(BPL)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .dump_sel(dump_sel),
        .dmem_base(dmem_base), .dmem_count(dmem_count),
        .debug_enable(debug_enable),
        .reg_debug_addr(reg_debug_addr), .reg_debug_rdata(reg_debug_rdata),
        .dmem_debug_addr(dmem_debug_addr), .dmem_debug_rdata(dmem_debug_rdata),
        .uart_txd(uart_txd), .busy(busy), .done(done)
    );

    // Debug-port models: r[i] = i*0x11, mem[a] = a[7:0], one-cycle read latency.
    always @(posedge clk) begin
        reg_debug_rdata  <= 8'(8'(reg_debug_addr) * 8'h11);
        dmem_debug_rdata <= dmem_debug_addr[7:0];
    end

    int tests_run = 0;
    int tests_failed = 0;
    logic [7:0]          exp_q[$];
    logic [D_ADDR_W-1:0] exp_addr_q[$];
    bit addr_chk_en = 0;
    bit addr_chk_mem = 0;
    bit cur_mem = 0;
    bit cnt0_mode = 0;
    int inv_err = 0;
    int done_cnt = 0;
    int done_before = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10);
    endfunction

    task automatic push_crlf();
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // Scoreboard model of one dump: characters and (optionally) read addresses.
    task automatic expect_dump(input bit sel, input logic [D_ADDR_W-1:0] base, input int cnt);
        int n;
        logic [D_ADDR_W-1:0] a;
        logic [7:0] b;
        n = sel ? cnt : NREG;
        if (n == 0) push_crlf();
        for (int i = 0; i < n; i++) begin
            a = sel ? (base + D_ADDR_W'(i)) : D_ADDR_W'(i);
            b = sel ? a[7:0] : 8'(i * 17);
            exp_q.push_back(hexc(b[7:4]));
            exp_q.push_back(hexc(b[3:0]));
            exp_q.push_back(8'h20);
            if (((i + 1) % BPL == 0) || (i == n - 1)) push_crlf();
            if (addr_chk_en) exp_addr_q.push_back(a);
        end
    endtask

    task automatic pulse_start(input bit sel, input logic [D_ADDR_W-1:0] base, input int cnt);
        @(posedge clk); #1;
        start = 1'b1; dump_sel = sel; dmem_base = base; dmem_count = (D_ADDR_W+1)'(cnt);
        cur_mem = sel; done_before = done_cnt;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k;
        k = 0;
        while (done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_rx_complete"}, exp_q.size(), 0);
        check({name, "_addr_complete"}, exp_addr_q.size(), 0);
        check({name, "_invariants"}, inv_err, 0);
        @(negedge clk);
        check({name, "_done_pulse_width"}, 32'(done), 32'd0);
        check({name, "_busy_low"}, 32'(busy), 32'd0);
        check({name, "_debug_enable_low"}, 32'(debug_enable), 32'd0);
        check({name, "_done_count"}, done_cnt - done_before, 1);
        $display("[TB] dump %s finished after %0d cycles", name, k);
        exp_q.delete();
        exp_addr_q.delete();
        inv_err = 0;
    endtask

    // UART monitor: decodes 8N1 frames by sampling mid-bit, scores each byte.
    initial begin
        int off;
        logic [7:0] rx;
        logic [7:0] e;
        off = -1;
        rx = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                off = -1;
            end else begin
                if (off < 0) begin
                    if (uart_txd === 1'b0) off = 0;
                end else begin
                    off++;
                end
                if (off == 2) begin
                    check("rx_start_bit", 32'(uart_txd), 32'd0);
                end else if (off >= 6 && off <= 34 && ((off - 6) % 4 == 0)) begin
                    rx[(off - 6) / 4] = uart_txd;
                end else if (off == 38) begin
                    check("rx_stop_bit", 32'(uart_txd), 32'd1);
                    tests_run++;
                    assert (exp_q.size() != 0) else begin
                        tests_failed++;
                        $error("FAIL rx_extra_char: observed=0x%02h expected=none", rx);
                    end
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("rx_char", 32'(rx), 32'(e));
                    end
                    off = -1;
                end
            end
        end
    end

    // Address monitor: logs the active debug address at dump start and on change.
    initial begin
        logic [D_ADDR_W-1:0] cur;
        logic [D_ADDR_W-1:0] prev;
        logic [D_ADDR_W-1:0] e;
        bit de_prev;
        prev = '0;
        de_prev = 0;
        forever begin
            @(negedge clk);
            cur = addr_chk_mem ? dmem_debug_addr : D_ADDR_W'(reg_debug_addr);
            if (reset_n && addr_chk_en && debug_enable === 1'b1 && (!de_prev || cur !== prev)) begin
                tests_run++;
                assert (exp_addr_q.size() != 0) else begin
                    tests_failed++;
                    $error("FAIL debug_addr_extra: observed=0x%0h expected=none", cur);
                end
                if (exp_addr_q.size() != 0) begin
                    e = exp_addr_q.pop_front();
                    check("debug_addr", 32'(cur), 32'(e));
                end
            end
            prev = cur;
            de_prev = reset_n && (debug_enable === 1'b1);
        end
    end

    // Continuous invariants and done counting.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (busy !== debug_enable) inv_err++;
                if (busy === 1'b1 && cur_mem && reg_debug_addr !== '0) inv_err++;
                if (busy === 1'b1 && !cur_mem && dmem_debug_addr !== '0) inv_err++;
                if (cnt0_mode && (reg_debug_addr !== '0 || dmem_debug_addr !== '0)) inv_err++;
                if (done === 1'b1) done_cnt++;
            end
        end
    end

    initial begin
        int k;
        logic [9:0] frame;
        logic exp_bit;

        // Reset state
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_debug_enable", 32'(debug_enable), 32'd0);
        check("rst_reg_addr", 32'(reg_debug_addr), 32'd0);
        check("rst_dmem_addr", 32'(dmem_debug_addr), 32'd0);
        check("rst_txd", 32'(uart_txd), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Register dump with a start pulse while busy (must be ignored)
        addr_chk_en = 1; addr_chk_mem = 0;
        expect_dump(0, '0, 0);
        pulse_start(0, '0, 0);
        check("busy_after_start", 32'(busy), 32'd1);
        repeat (300) @(posedge clk);
        #1;
        check("busy_before_ignored_start", 32'(busy), 32'd1);
        start = 1'b1; dump_sel = 1'b1; dmem_base = 12'h055; dmem_count = 13'd5;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("reg_dump", 6000);
        addr_chk_en = 0;

        // Memory dump spanning a line break
        expect_dump(1, 12'h010, 20);
        pulse_start(1, 12'h010, 20);
        wait_done("mem_20", 8000);

        // Line boundary coinciding with the end: single CR LF
        expect_dump(1, 12'h030, 16);
        pulse_start(1, 12'h030, 16);
        wait_done("mem_16", 6000);

        // Address wrap
        addr_chk_en = 1; addr_chk_mem = 1;
        expect_dump(1, 12'hFFE, 3);
        pulse_start(1, 12'hFFE, 3);
        wait_done("wrap", 2000);
        addr_chk_en = 0;

        // Empty window
        cnt0_mode = 1;
        expect_dump(1, 12'h123, 0);
        pulse_start(1, 12'h123, 0);
        wait_done("count0", 1000);
        cnt0_mode = 0;

        // Reset during the second frame
        exp_q.push_back(8'h30);
        pulse_start(0, '0, 0);
        k = 0;
        while (uart_txd !== 1'b0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("abort_first_frame_seen", 32'(uart_txd), 32'd0);
        repeat (41) @(negedge clk);
        check("abort_frame2_start_bit", 32'(uart_txd), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_txd_high", 32'(uart_txd), 32'd1);
        check("abort_busy_low", 32'(busy), 32'd0);
        check("abort_debug_enable_low", 32'(debug_enable), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("abort_rx_first_char", exp_q.size(), 0);
        exp_q.delete();
        inv_err = 0;
        $display("[TB] dump abort reset applied mid-frame");

        // New start after reset; exact bit timing of 'A' and back-to-back '0'
        expect_dump(1, 12'h0A0, 1);
        pulse_start(1, 12'h0A0, 1);
        k = 0;
        while (uart_txd !== 1'b0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        frame = {1'b1, 8'h41, 1'b0};
        for (int c = 0; c < 41; c++) begin
            exp_bit = (c < 40) ? frame[c / CPB] : 1'b0;
            check("txd_bit_timing", 32'(uart_txd), 32'(exp_bit));
            @(negedge clk);
        end
        wait_done("after_reset", 2000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
